// File: rtl/render_scheduler_pkg.sv
// Shared types and constants for the render scheduler slice.
// Pure declarations: no logic, no latency.
// No handshake of its own; consumed by render_scheduler and pixel_counter.
package render_scheduler_pkg;

    // 16.16 unsigned fixed-point distance along a ray
    typedef logic [31:0] fixed_real;

    // 8:8:8 RGB pixel color
    typedef logic [23:0] color_t;

    // 3-component fixed-point vector (ray origins/directions upstream)
    typedef struct packed {
        fixed_real x;
        fixed_real y;
        fixed_real z;
    } vector_t;

    localparam int        H_RES         = 640;
    localparam int        V_RES         = 480;
    localparam fixed_real T_FAR_DEFAULT = 32'h0100_0000;
    localparam color_t    COLOR_BLACK   = 24'h000000;

endpackage

// File: rtl/render_scheduler_if.sv
// Bundles the scheduler's control, collision and frame-buffer signals.
// Wires only, no latency.
// fb_we/fb_ack is a hold-until-accepted handshake; collision inputs have fixed timing.
interface render_scheduler_if;
    import render_scheduler_pkg::*;

    logic       start;
    logic       busy;
    logic       frame_done;
    logic [9:0] write_x;
    logic [9:0] write_y;
    logic [3:0] sph_idx;
    fixed_real  tbest;
    logic       collide;
    fixed_real  tnew;
    color_t     sph_col;
    logic       fb_we;
    color_t     fb_color;
    logic       fb_ack;

    // scheduler side
    modport master (
        input  start, collide, tnew, sph_col, fb_ack,
        output busy, frame_done, write_x, write_y, sph_idx, tbest, fb_we, fb_color
    );

    // environment side: collision unit, frame buffer and host
    modport slave (
        output start, collide, tnew, sph_col, fb_ack,
        input  busy, frame_done, write_x, write_y, sph_idx, tbest, fb_we, fb_color
    );

endinterface

// File: rtl/render_scheduler_pixel_counter.sv
// Raster counter: current pixel (x,y) with row wrap and a last-pixel flag.
// clear/advance take effect on the next rising edge; last is combinational.
// No backpressure: the caller only pulses advance when the pixel is done.
module pixel_counter
    import render_scheduler_pkg::*;
#(
    parameter int H_PIX = H_RES,
    parameter int V_PIX = V_RES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       last
);

    localparam logic [9:0] X_LAST = 10'(H_PIX - 1);
    localparam logic [9:0] Y_LAST = 10'(V_PIX - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    // raster walk: x fastest, wrap to the next row, wrap the frame back to origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? 10'd0 : y + 10'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

endmodule

// File: rtl/render_scheduler.sv
// Per-pixel render FSM: ray setup, nearest-hit sphere scan, frame-buffer write. Option: SKY_GRADIENT_EN.
// Latency per pixel = LUT_LAT + 2*NUM_SPHERES + 2 cycles when fb_ack is high.
// WRITE holds fb_we/address/color until fb_ack, indefinitely; start is ignored unless idle.
module render_scheduler
    import render_scheduler_pkg::*;
#(
    parameter int        NUM_SPHERES = 4,
    parameter int        LUT_LAT     = 2,
    parameter fixed_real T_FAR       = T_FAR_DEFAULT,
    parameter int        H_PIX       = H_RES,
    parameter int        V_PIX       = V_RES
) (
    input  logic               clk,
    input  logic               rst_n,
    render_scheduler_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RAY   = 3'd1;
    localparam logic [2:0] S_TEST  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    localparam int              RAY_W    = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;
    localparam logic [RAY_W-1:0] RAY_LAST = RAY_W'(LUT_LAT - 1);
    localparam logic [3:0]       SPH_LAST = 4'(NUM_SPHERES - 1);

    logic [2:0]       state;
    logic [RAY_W-1:0] ray_cnt;
    logic             phase;      // 0: slot presented, 1: collision result sampled
    logic [3:0]       sph_idx;
    fixed_real        tbest;
    color_t           color;
    logic             busy;
    logic             frame_done;
    color_t           background;

    logic             cnt_clear;
    logic             cnt_advance;
    logic             last_pixel;
    logic [9:0]       write_x;
    logic [9:0]       write_y;

`ifdef SKY_GRADIENT_EN
    // blue that fades towards the bottom of the frame
    assign background = {16'h0000, 8'hFF - write_y[8:1]};
`else
    assign background = COLOR_BLACK;
`endif

    assign cnt_clear   = (state == S_IDLE) && bus.start;
    assign cnt_advance = (state == S_NEXT);

    pixel_counter #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX)
    ) u_pixel_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .x       (write_x),
        .y       (write_y),
        .last    (last_pixel)
    );

    // pixel FSM; tbest at T_FAR doubles as the "no hit yet" marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ray_cnt    <= '0;
            phase      <= 1'b0;
            sph_idx    <= '0;
            tbest      <= T_FAR;
            color      <= COLOR_BLACK;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= bus.start;
                    if (bus.start) begin
                        state   <= S_RAY;
                        ray_cnt <= '0;
                    end
                end
                S_RAY: begin
                    if (ray_cnt == RAY_LAST) begin
                        state   <= S_TEST;
                        phase   <= 1'b0;
                        sph_idx <= '0;
                        tbest   <= T_FAR;
                        color   <= background;
                    end else begin
                        ray_cnt <= ray_cnt + RAY_W'(1);
                    end
                end
                S_TEST: begin
                    phase <= ~phase;
                    if (phase) begin
                        // strict less-than keeps the lower slot on a tie
                        if (bus.collide && (bus.tnew < tbest)) begin
                            tbest <= bus.tnew;
                            color <= bus.sph_col;
                        end
                        if (sph_idx == SPH_LAST) begin
                            state <= S_WRITE;
                        end else begin
                            sph_idx <= sph_idx + 4'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.fb_ack) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    ray_cnt <= '0;
                    if (last_pixel) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end else begin
                        state <= S_RAY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.write_x    = write_x;
    assign bus.write_y    = write_y;
    assign bus.sph_idx    = sph_idx;
    assign bus.tbest      = tbest;
    assign bus.fb_we      = (state == S_WRITE);
    assign bus.fb_color   = color;

endmodule

// File: tb/tb_render_scheduler.sv
// Scoreboarded bench for render_scheduler on a reduced raster.
// Expected writes are queued by the stimulus and popped by a negedge monitor.
// fb_ack is stalled 5 cycles at pixel (3,0).
`timescale 1ns/1ps
module tb_render_scheduler;
    import render_scheduler_pkg::*;

    localparam int        NS      = 2;
    localparam int        LL      = 1;
    localparam int        HP      = 104;
    localparam int        VP      = 51;
    localparam fixed_real TF      = 32'h0100_0000;
    localparam int        PIX_CYC = 7;   // LL + 2*NS + 2

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    render_scheduler_if bus();

    render_scheduler #(
        .NUM_SPHERES (NS),
        .LUT_LAT     (LL),
        .T_FAR       (TF),
        .H_PIX       (HP),
        .V_PIX       (VP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // directed collision vectors for pixels (0..4, 0), slot0 then slot1
    typedef struct {
        logic      c0; fixed_real t0; color_t k0;
        logic      c1; fixed_real t1; color_t k1;
        logic      hit; color_t ec; fixed_real et;
    } vec_t;
    vec_t vt [5];

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        color_t     col;
        fixed_real  t;
    } wr_t;
    wr_t exp_q [$];

    initial begin
        // nearer slot1 wins
        vt[0] = '{1'b1, 32'h0002_0000, 24'hFF0000, 1'b1, 32'h0001_0000, 24'h00FF00, 1'b1, 24'h00FF00, 32'h0001_0000};
        // tie: slot0 kept
        vt[1] = '{1'b1, 32'h0003_0000, 24'h0000AA, 1'b1, 32'h0003_0000, 24'h0000BB, 1'b1, 24'h0000AA, 32'h0003_0000};
        // tnew equal to / above T_FAR never hits
        vt[2] = '{1'b1, 32'h0100_0000, 24'hAAAAAA, 1'b1, 32'h0100_0001, 24'hBBBBBB, 1'b0, 24'h000000, 32'h0100_0000};
        // slot0 has tnew=0 but no collide
        vt[3] = '{1'b0, 32'h0000_0000, 24'hFFFFFF, 1'b1, 32'h0000_0005, 24'h123456, 1'b1, 24'h123456, 32'h0000_0005};
        // just below T_FAR hits; slot1 tnew=0 without collide ignored
        vt[4] = '{1'b1, 32'h00FF_FFFF, 24'hABCDEF, 1'b0, 32'h0000_0000, 24'h111111, 1'b1, 24'hABCDEF, 32'h00FF_FFFF};
    end

    function automatic wr_t expect_px(input int x, input int y);
        wr_t w;
        w.x = 10'(x);
        w.y = 10'(y);
        w.t = TF;
`ifdef SKY_GRADIENT_EN
        w.col = {16'h0000, 8'hFF - w.y[8:1]};
`else
        w.col = 24'h000000;
`endif
        if (y == 0 && x < 5 && vt[x].hit) begin
            w.col = vt[x].ec;
            w.t   = vt[x].et;
        end
        return w;
    endfunction

    // collision unit model: result for the presented slot
    always @(negedge clk) begin
        if (bus.write_y == 10'd0 && bus.write_x < 10'd5 && bus.sph_idx < 4'd2) begin
            if (bus.sph_idx == 4'd0) begin
                bus.collide = vt[bus.write_x].c0;
                bus.tnew    = vt[bus.write_x].t0;
                bus.sph_col = vt[bus.write_x].k0;
            end else begin
                bus.collide = vt[bus.write_x].c1;
                bus.tnew    = vt[bus.write_x].t1;
                bus.sph_col = vt[bus.write_x].k1;
            end
        end else begin
            bus.collide = 1'b0;
            bus.tnew    = 32'h0000_0000;
            bus.sph_col = 24'hFFFFFF;
        end
    end

    // frame buffer model: stalls 5 cycles on pixel (3,0)
    int stall_left = 5;
    always @(posedge clk) begin
        #2;
        if (bus.fb_we && bus.write_x == 10'd3 && bus.write_y == 10'd0) begin
            if (stall_left > 0) begin
                bus.fb_ack = 1'b0;
                stall_left--;
            end else begin
                bus.fb_ack = 1'b1;
            end
        end else begin
            bus.fb_ack = 1'b1;
            stall_left = 5;
        end
    end

    int   cyc = 0;
    always @(posedge clk) cyc++;

    int          last_wr      = -1;
    int          we_run       = 0;
    logic [43:0] hold;
    logic        unstable     = 1'b0;
    logic        done_allowed = 1'b0;
    int          done_seen    = 0;

    // monitor: pops an expected write on every accepted fb_we
    always @(negedge clk) begin
        wr_t w;
        wr_t a;
        if (!rst_n) begin
            we_run  = 0;
            last_wr = -1;
        end else begin
            if (bus.fb_we) begin
                if (we_run == 0) begin
                    hold     = {bus.write_x, bus.write_y, bus.fb_color};
                    unstable = 1'b0;
                end else if (hold != {bus.write_x, bus.write_y, bus.fb_color}) begin
                    unstable = 1'b1;
                end
                we_run++;
                if (bus.fb_ack) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got write at (%0d,%0d) required none",
                                 bus.write_x, bus.write_y);
                    end else begin
                        w     = exp_q.pop_front();
                        a.x   = bus.write_x;
                        a.y   = bus.write_y;
                        a.col = bus.fb_color;
                        a.t   = bus.tbest;
                        check("pixel_write{x,y,col,tbest}", 96'(a), 96'(w));
                        if (w.x == 10'd3 && w.y == 10'd0) begin
                            check("stall_fb_we_cycles", 96'(we_run), 96'(6));
                            check("stall_hold_stable", 96'(unstable), 96'(0));
                        end
                        if (last_wr >= 0 && w.y == 10'd0 && w.x >= 10'd1 && w.x <= 10'd4)
                            check("pixel_latency", 96'(cyc - last_wr),
                                  96'((w.x == 10'd3) ? PIX_CYC + 5 : PIX_CYC));
                    end
                    last_wr = cyc;
                    we_run  = 0;
                end
            end
            if (bus.frame_done) begin
                check("frame_done_allowed", 96'(done_allowed), 96'(1));
                check("queue_empty_at_done", 96'(exp_q.size()), 96'(0));
                done_seen++;
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_busy"},       96'(bus.busy),       96'(0));
        check({tag, "_frame_done"}, 96'(bus.frame_done), 96'(0));
        check({tag, "_fb_we"},      96'(bus.fb_we),      96'(0));
        check({tag, "_write_x"},    96'(bus.write_x),    96'(0));
        check({tag, "_write_y"},    96'(bus.write_y),    96'(0));
        check({tag, "_sph_idx"},    96'(bus.sph_idx),    96'(0));
        check({tag, "_tbest"},      96'(bus.tbest),      96'(TF));
        check({tag, "_fb_color"},   96'(bus.fb_color),   96'(0));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic push_frame();
        for (int y = 0; y < VP; y++)
            for (int x = 0; x < HP; x++)
                exp_q.push_back(expect_px(x, y));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no end of test required end before 1.5ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        bus.start   = 1'b0;
        bus.collide = 1'b0;
        bus.tnew    = '0;
        bus.sph_col = '0;
        bus.fb_ack  = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // frame 1: full raster, directed hits on row 0
        push_frame();
        done_allowed = 1'b1;
        pulse_start();
        check("busy_after_start", 96'(bus.busy), 96'(1));
        repeat (20) @(negedge clk);
        pulse_start();   // ignored while busy
        found = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                found = 1'b1;
                break;
            end
        end
        check("frame_done_seen", 96'(found), 96'(1));
        check("busy_with_frame_done", 96'(bus.busy), 96'(1));
        @(negedge clk);
        done_allowed = 1'b0;
        check("busy_after_done", 96'(bus.busy), 96'(0));
        check("frame_done_one_cycle", 96'(bus.frame_done), 96'(0));

        // frame 2: aborted by reset at pixel (100,50)
        push_frame();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (bus.write_x == 10'd100 && bus.write_y == 10'd50) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_100_50", 96'(found), 96'(1));
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset("midframe");
        @(negedge clk);
        rst_n = 1'b1;

        // frame 3: restarts at origin
        for (int x = 0; x < 6; x++)
            exp_q.push_back(expect_px(x, 0));
        pulse_start();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            @(negedge clk);
        check("restart_writes_done", 96'(exp_q.size()), 96'(0));
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("frame_done_count", 96'(done_seen), 96'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 Parameter NUM_SPHERES, default 4, number of sphere slots scanned per pixel (1..16).
REQ-002 Parameter LUT_LAT, default 2, cycles from pixel coordinate change to valid ray from the angle and ray LUTs.
REQ-003 Parameter T_FAR, default 32'h01000000, initial tbest (16.16 fixed_real).
REQ-004 Clk  in  1  single system clock; all state on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a frame render when idle.
REQ-007 busy  out  1  high from the start-accept cycle through the cycle frame_done is asserted.
REQ-008 frame_done  out  1  one-cycle pulse after the last pixel write is acknowledged.
REQ-009 WriteX / WriteY  out  10 / 10  current pixel coordinate; drives the angle LUTs and the frame_buffer write address.
REQ-010 sph_idx  out  4  sphere slot presented to collision_detection.
REQ-011 tbest  out  32  running nearest hit distance fed to collision_detection.
REQ-012 collide / tnew  in  1 / 32  collision result for sph_idx, valid the cycle after sph_idx changes.
REQ-013 sph_col  in  24  color of slot sph_idx, same timing as collide.
REQ-014 fb_we / fb_color  out  1 / 24  frame_buffer write request and pixel color.
REQ-015 fb_ack  in  1  frame_buffer accepts the write on a cycle where fb_we and fb_ack are both high.

Function
REQ-016 States SHALL be IDLE, RAY, TEST, WRITE, NEXT.
REQ-017 IDLE: start sets WriteX=WriteY=0 and enters RAY the next cycle; start outside IDLE is ignored.
REQ-018 RAY: the state lasts exactly LUT_LAT cycles; on exit tbest=T_FAR, sph_idx=0, hit flag clear, color=background.
REQ-019 TEST: sph_idx advances one slot every 2 cycles (present, sample); NUM_SPHERES*2 cycles total.
REQ-020 On sample, if collide=1 and tnew < tbest (unsigned), tbest<=tnew and the pixel color<=sph_col.
REQ-021 On equal tnew, the lower slot index wins (no update).
REQ-022 WRITE: fb_we held high with stable WriteX/WriteY/fb_color until fb_ack; no timeout.
REQ-023 NEXT: WriteX increments; at 639 it wraps to 0 and WriteY increments; at (639,479) frame_done pulses and the FSM returns to IDLE, otherwise to RAY.
REQ-024 Pixel latency with fb_ack tied high = LUT_LAT + 2*NUM_SPHERES + 2 cycles.
REQ-025 Without SKY_GRADIENT_EN, background is 24'h000000.

Reset
REQ-026 Reset_n low SHALL immediately force IDLE, busy=0, frame_done=0, fb_we=0, WriteX=WriteY=0, sph_idx=0, tbest=T_FAR, fb_color=0.
REQ-027 Reset mid-frame abandons the frame; no frame_done is produced, and the next start restarts at (0,0).

Configuration
REQ-028 Macro SKY_GRADIENT_EN defined: background = {8'h00, 8'h00, 8'hFF - WriteY[8:1]} (blue fading down); undefined: constant black per REQ-025; no other behaviour changes.

Structure
REQ-029 Shared package holds the vector, fixed_real, and color typedefs, along with the constants H_RES=640, V_RES=480, and the default T_FAR.
REQ-030 Raster counter (WriteX/WriteY with wrap and last-pixel flag) SHALL be sub-module pixel_counter; all else lives in render_scheduler.

Verification
REQ-031 NUM_SPHERES=1, collide always 0, fb_ack=1 -> every fb_color=24'h000000, frame_done after 640*480 writes, busy low the following cycle.
REQ-032 Slot0 collide tnew=32'h00020000 col FF0000, slot1 tnew=32'h00010000 col 00FF00 -> fb_color=00FF00, tbest ends at 32'h00010000.
REQ-033 Two slots, both tnew=32'h00030000 -> slot0 color is written (tie rule).
REQ-034 fb_ack held low 5 cycles at pixel (3,0) -> fb_we stays high and address/color stay stable for 6 cycles; the pixel is written once.
REQ-035 Reset_n pulsed low at pixel (100,50), then start -> first write at (0,0) and no frame_done from the aborted frame.
REQ-036 SKY_GRADIENT_EN defined, no hits -> pixel at WriteY=0 has color 0000FF; pixel at WriteY=478 has color 000010.
